// File: rtl/fp_normalize_pkg.sv
// Shared types and constants for the fp_normalize post-add/sub normalization stage.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int EXP_W      = 8;
  localparam int MANT_W     = 28;
  localparam int HIDDEN_BIT = 26;
  localparam int CARRY_BIT  = 27;
  localparam int EXP_MAX    = 255;

  // 9-bit unsigned minimum used by the shift-distance selection.
  function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fp_normalize_if.sv
// Handshake and data bundle for fp_normalize.
// master: upstream/downstream environment; slave: the normalizer itself.
interface fp_normalize_if;
  import fp_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [EXP_W-1:0]    exp;
  logic [MANT_W-1:0]   mantis;
  logic                operator;

  logic                out_valid;
  logic                out_ready;
  logic [EXP_W-1:0]    exp_out;
  logic [MANT_W-1:0]   mantis_out;
  logic                operator_out;
  logic                zero;
  logic                overflow;

  modport master (
    output in_valid, exp, mantis, operator, out_ready,
    input  in_ready, out_valid, exp_out, mantis_out, operator_out, zero, overflow
  );

  modport slave (
    input  in_valid, exp, mantis, operator, out_ready,
    output in_ready, out_valid, exp_out, mantis_out, operator_out, zero, overflow
  );

endinterface

// File: rtl/fp_normalize_lzc28.sv
// Combinational leading-zero count of a 27-bit field (hidden bit downward).
// Returns 27 when the whole field is zero.
module lzc28 (
  input  logic [26:0] mant,
  output logic [4:0]  lz
);

  logic found;

  // Scan from the hidden-bit position down; the first set bit fixes the count.
  always_comb begin
    lz    = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && mant[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_normalize.sv
// Post-add/sub normalization stage: iterative left shifter with carry,
// zero, overflow and denormal handling, valid/ready on both sides.
// Optional build macro FP_NORM_LZC_FAST_EN: the left shift jumps the full
// leading-zero distance in one cycle instead of at most STEP per cycle.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// NORM  | evaluating carry/zero/overflow/shift rules on the working regs
// DONE  | result held on the outputs until out_ready
module fp_normalize
  import fp_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_normalize_if.slave  bus
);

  state_t state, state_nxt;

  logic [8:0]        w_exp;
  logic [MANT_W-1:0] w_mant;
  logic              w_op;
  logic              w_zero;
  logic              w_ovf;

  logic [8:0]        n_exp;
  logic [MANT_W-1:0] n_mant;
  logic              n_zero;
  logic              n_ovf;
  logic              norm_done;

  logic [4:0]        lz;
  logic [8:0]        exp_m1;
  logic [8:0]        k_lz;
  logic [8:0]        k;
  logic              accept;

  assign accept = bus.in_valid && (state == IDLE);

  lzc28 u_lzc (
    .mant (w_mant[HIDDEN_BIT:0]),
    .lz   (lz)
  );

  // Shift distance: never more than the leading zeros, never pushing exp below 1.
  always_comb begin
    exp_m1 = w_exp - 9'd1;
    k_lz   = min9({4'd0, lz}, exp_m1);
`ifdef FP_NORM_LZC_FAST_EN
    k      = k_lz;
`else
    k      = min9(k_lz, 9'(STEP));
`endif
  end

  // One NORM evaluation; the first matching rule wins.
  always_comb begin
    n_exp     = w_exp;
    n_mant    = w_mant;
    n_zero    = w_zero;
    n_ovf     = w_ovf;
    norm_done = 1'b0;
    if (w_mant == '0) begin
      n_exp     = 9'd0;
      n_zero    = 1'b1;
      norm_done = 1'b1;
    end else if (w_mant[CARRY_BIT] && (w_exp >= 9'd254)) begin
      n_exp     = 9'(EXP_MAX);
      n_mant    = '0;
      n_ovf     = 1'b1;
      norm_done = 1'b1;
    end else if (w_mant[CARRY_BIT]) begin
      // Single right shift; the bit shifted out folds into the sticky bit.
      n_mant    = {1'b0, w_mant[MANT_W-1:1]};
      n_mant[0] = w_mant[1] | w_mant[0];
      n_exp     = w_exp + 9'd1;
      norm_done = 1'b1;
    end else if (w_mant[HIDDEN_BIT]) begin
      norm_done = 1'b1;
    end else if (w_exp == 9'd0) begin
      norm_done = 1'b1;
    end else if (w_exp == 9'd1) begin
      // Denormal encoding: exponent drops to 0, mantissa stays put.
      n_exp     = 9'd0;
      norm_done = 1'b1;
    end else begin
      n_mant    = w_mant << k;
      n_exp     = w_exp - k;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = NORM;
      NORM:    if (norm_done)     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // Working registers: load on accept, update every NORM cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_exp  <= '0;
      w_mant <= '0;
      w_op   <= 1'b0;
      w_zero <= 1'b0;
      w_ovf  <= 1'b0;
    end else if (accept) begin
      w_exp  <= {1'b0, bus.exp};
      w_mant <= bus.mantis;
      w_op   <= bus.operator;
      w_zero <= 1'b0;
      w_ovf  <= 1'b0;
    end else if (state == NORM) begin
      w_exp  <= n_exp;
      w_mant <= n_mant;
      w_zero <= n_zero;
      w_ovf  <= n_ovf;
    end
  end

  // Result registers: written only on the NORM->DONE transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.exp_out      <= '0;
      bus.mantis_out   <= '0;
      bus.operator_out <= 1'b0;
      bus.zero         <= 1'b0;
      bus.overflow     <= 1'b0;
    end else if ((state == NORM) && norm_done) begin
      bus.exp_out      <= n_exp[EXP_W-1:0];
      bus.mantis_out   <= n_mant;
      bus.operator_out <= w_op;
      bus.zero         <= n_zero;
      bus.overflow     <= n_ovf;
    end
  end

endmodule

// File: tb/tb_fp_normalize.sv
// Self-checking bench for fp_normalize: directed cases, backpressure,
// reset during shifting and random operands against a reference model.
module tb_fp_normalize;
  import fp_pkg::*;

  localparam int STEP_P = 1;

  typedef struct packed {
    logic [38:0] res;  // {exp_out, mantis_out, zero, overflow, operator_out}
    logic [7:0]  lat;
  } sb_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  sb_t  sb_q[$];

  fp_normalize_if bus ();

  fp_normalize #(.STEP(STEP_P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [38:0] actual_res();
    return {bus.exp_out, bus.mantis_out, bus.zero, bus.overflow, bus.operator_out};
  endfunction

  function automatic sb_t mk(input logic [7:0] e, input logic [27:0] m, input logic z,
                             input logic ov, input logic op, input int lat);
    sb_t s;
    s.res = {e, m, z, ov, op};
    s.lat = 8'(lat);
    return s;
  endfunction

  // Reference model of the normalization rules, counting shift cycles.
  function automatic sb_t model(input logic [7:0] e, input logic [27:0] m, input logic op);
    int x, lat, lz, k;
    logic [27:0] mm;
    logic z, ov;
    bit fin;
    x = int'(e); mm = m; z = 1'b0; ov = 1'b0; lat = 2; fin = 1'b0;
    for (int it = 0; it < 40 && !fin; it++) begin
      if (mm == 28'd0) begin
        x = 0; z = 1'b1; fin = 1'b1;
      end else if (mm[27] && x >= 254) begin
        x = 255; mm = 28'd0; ov = 1'b1; fin = 1'b1;
      end else if (mm[27]) begin
        mm = (mm >> 1) | {27'd0, mm[0]}; x = x + 1; fin = 1'b1;
      end else if (mm[26]) begin
        fin = 1'b1;
      end else if (x == 0) begin
        fin = 1'b1;
      end else if (x == 1) begin
        x = 0; fin = 1'b1;
      end else begin
        lz = 27;
        for (int b = 26; b >= 0; b--) begin
          if (mm[b] && lz == 27) lz = 26 - b;
        end
        k = (lz < x - 1) ? lz : x - 1;
`ifndef FP_NORM_LZC_FAST_EN
        if (STEP_P < k) k = STEP_P;
`endif
        mm = mm << k;
        x  = x - k;
        lat++;
      end
    end
    return mk(8'(x), mm, z, ov, op, lat);
  endfunction

  // Present one operand at a negedge while idle; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] e, input logic [27:0] m, input logic op);
    bus.exp      = e;
    bus.mantis   = m;
    bus.operator = op;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Latency counted with the accept edge as cycle 1; bounded wait.
  task automatic wait_result(output int lat, output bit timeout);
    lat = 1;
    timeout = 1'b0;
    while (bus.out_valid !== 1'b1) begin
      if (lat > 60) begin
        timeout = 1'b1;
        return;
      end
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [40:0] exp_v;
    exp_v = {1'b1, 1'b0, 39'd0};
    n_vec++;
    if ({bus.in_ready, bus.out_valid, actual_res()} !== exp_v) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", {bus.in_ready, bus.out_valid, actual_res()}, exp_v);
    end
  endtask

  task automatic test_directed(input string name, input logic [7:0] e, input logic [27:0] m,
                               input logic op, input sb_t expv);
    int lat; bit to; sb_t s;
    sb_q.push_back(expv);
    send(e, m, op);
    wait_result(lat, to);
    s = sb_q.pop_front();
    n_vec++;
    if (to) begin
      n_err++;
      $display("FAIL %s_timeout: out_valid never rose, waited %0d cycles", name, lat);
    end else begin
      if (actual_res() !== s.res) begin
        n_err++;
        $display("FAIL %s_value: got %h want %h", name, actual_res(), s.res);
      end
      n_vec++;
      if (lat !== int'(s.lat)) begin
        n_err++;
        $display("FAIL %s_latency: got %0d want %0d", name, lat, s.lat);
      end
    end
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_consume: out_valid %b in_ready %b want 0 1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_carry();
    test_directed("carry", 8'd127, 28'h8000003, 1'b1, mk(8'd128, 28'h4000001, 1'b0, 1'b0, 1'b1, 2));
  endtask

  task automatic test_left_norm();
`ifdef FP_NORM_LZC_FAST_EN
    test_directed("left_norm", 8'd127, 28'h0800000, 1'b0, mk(8'd124, 28'h4000000, 1'b0, 1'b0, 1'b0, 3));
`else
    test_directed("left_norm", 8'd127, 28'h0800000, 1'b0, mk(8'd124, 28'h4000000, 1'b0, 1'b0, 1'b0, 5));
`endif
  endtask

  task automatic test_denorm();
`ifdef FP_NORM_LZC_FAST_EN
    test_directed("denorm", 8'd3, 28'h0100000, 1'b1, mk(8'd0, 28'h0400000, 1'b0, 1'b0, 1'b1, 3));
`else
    test_directed("denorm", 8'd3, 28'h0100000, 1'b1, mk(8'd0, 28'h0400000, 1'b0, 1'b0, 1'b1, 4));
`endif
  endtask

  task automatic test_zero_ovf();
    test_directed("zero", 8'd90, 28'h0000000, 1'b0, mk(8'd0, 28'h0000000, 1'b1, 1'b0, 1'b0, 2));
    test_directed("overflow", 8'd254, 28'h8000000, 1'b0, mk(8'd255, 28'h0000000, 1'b0, 1'b1, 1'b0, 2));
  endtask

  task automatic test_backpressure();
    int lat; bit to; sb_t s;
    bus.out_ready = 1'b0;
    sb_q.push_back(model(8'd127, 28'h0800000, 1'b1));
    send(8'd127, 28'h0800000, 1'b1);
    wait_result(lat, to);
    s = sb_q.pop_front();
    n_vec++;
    if (to || actual_res() !== s.res) begin
      n_err++;
      $display("FAIL bp_value: got %h want %h timeout %b", actual_res(), s.res, to);
    end
    for (int i = 0; i < 10; i++) begin
      bus.exp      = 8'd1;
      bus.mantis   = 28'hFFFFFFF;
      bus.operator = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      n_vec++;
      if (actual_res() !== s.res || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got %h rdy %b vld %b want %h 0 1",
                 i, actual_res(), bus.in_ready, bus.out_valid, s.res);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: out_valid %b in_ready %b want 0 1", bus.out_valid, bus.in_ready);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0 || actual_res() !== s.res) begin
      n_err++;
      $display("FAIL bp_ignored: out_valid %b res %h want 0 %h", bus.out_valid, actual_res(), s.res);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    sb_q.push_back(model(8'd127, 28'h0000001, 1'b1));
    send(8'd127, 28'h0000001, 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.in_ready, bus.out_valid, actual_res()} !== {1'b1, 1'b0, 39'd0}) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got %h want %h",
               {bus.in_ready, bus.out_valid, actual_res()}, {1'b1, 1'b0, 39'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb_q.pop_front());
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 || bus.in_ready !== 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_stale: stale activity %b want 0", seen);
    end
  endtask

  task automatic test_random();
    int lat; bit to; sb_t s;
    logic [7:0] e; logic [27:0] m; logic op;
    for (int i = 0; i < 24; i++) begin
      e  = 8'($urandom_range(0, 255));
      m  = 28'($urandom) >> $urandom_range(0, 27);
      op = 1'($urandom);
      if (i % 6 == 0) m[27] = 1'b1;
      if (i % 8 == 1) e = 8'($urandom_range(250, 255));
      sb_q.push_back(model(e, m, op));
      send(e, m, op);
      wait_result(lat, to);
      s = sb_q.pop_front();
      n_vec++;
      if (to || actual_res() !== s.res || lat !== int'(s.lat)) begin
        n_err++;
        $display("FAIL random_%0d: in %h/%h got %h lat %0d want %h lat %0d timeout %b",
                 i, e, m, actual_res(), lat, s.res, s.lat, to);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.exp       = 8'd0;
    bus.mantis    = 28'd0;
    bus.operator  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_carry();
    test_left_norm();
    test_denorm();
    test_zero_ovf();
    test_backpressure();
    test_reset_mid();
    test_carry();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
